// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller: ctrl_state_e, the FSM state enum,
// the bundle of register enables/flushes, and the action decode used by pipeline_ctrl.
package pipe_ctrl_pkg;

    localparam int unsigned RegAddrWidthDefault = 5;

    typedef enum logic [1:0] {
        CtrlRun       = 2'd0,
        CtrlLoadStall = 2'd1,
        CtrlExWait    = 2'd2,
        CtrlMemWait   = 2'd3
    } ctrl_state_e;

    typedef enum logic {
        ExIdle = 1'b0,
        ExBusy = 1'b1
    } ex_state_e;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
    } pipe_ctrl_t;

    // Maps the chosen action to register controls; a flush is only ever paired with its enable.
    function automatic pipe_ctrl_t ctrl_action(input ctrl_state_e st, input logic redirect);
        pipe_ctrl_t c;
        c = '0;
        unique case (st)
            CtrlMemWait: c = '0;
            CtrlExWait: begin
                c.ex_mem_en    = 1'b1;
                c.ex_mem_flush = 1'b1;
                c.mem_wb_en    = 1'b1;
            end
            CtrlLoadStall: begin
                c.id_ex_en    = 1'b1;
                c.id_ex_flush = 1'b1;
                c.ex_mem_en   = 1'b1;
                c.mem_wb_en   = 1'b1;
            end
            CtrlRun: begin
                c.pc_en       = 1'b1;
                c.if_id_en    = 1'b1;
                c.id_ex_en    = 1'b1;
                c.ex_mem_en   = 1'b1;
                c.mem_wb_en   = 1'b1;
                c.if_id_flush = redirect;
                c.id_ex_flush = redirect;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard comparator: ID reads a register that the load in EX writes.
// Register 0 never creates a hazard.
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH = RegAddrWidthDefault
) (
    input  logic                      id_valid_i,
    input  logic                      id_uses_rs1_i,
    input  logic                      id_uses_rs2_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_i,
    input  logic                      ex_valid_i,
    input  logic                      ex_is_load_i,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_i,
    output logic                      load_use_o
);

    logic rs1_hit;
    logic rs2_hit;
    logic ex_load_live;

    assign ex_load_live = ex_valid_i && ex_is_load_i && (ex_rd_i != '0);
    assign rs1_hit      = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
    assign rs2_hit      = id_uses_rs2_i && (id_rs2_i == ex_rd_i);
    assign load_use_o   = id_valid_i && ex_load_live && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
// Define PIPE_CTRL_PERF_EN to add saturating stall-cycle and redirect-flush counters.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH = RegAddrWidthDefault
`ifdef PIPE_CTRL_PERF_EN
    ,
    parameter int unsigned PERF_WIDTH = 32
`endif
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      id_valid_i,
    input  logic                      id_uses_rs1_i,
    input  logic                      id_uses_rs2_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_i,
    input  logic                      ex_valid_i,
    input  logic                      ex_is_load_i,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_i,
    input  logic                      ex_mc_start_i,
    input  logic                      ex_mc_done_i,
    input  logic                      ex_redirect_i,
    input  logic                      mem_req_i,
    input  logic                      mem_ready_i,
    output logic                      pc_en_o,
    output logic                      if_id_en_o,
    output logic                      id_ex_en_o,
    output logic                      ex_mem_en_o,
    output logic                      mem_wb_en_o,
    output logic                      if_id_flush_o,
    output logic                      id_ex_flush_o,
    output logic                      ex_mem_flush_o,
`ifdef PIPE_CTRL_PERF_EN
    output logic [PERF_WIDTH-1:0]     perf_stall_cycles_o,
    output logic [PERF_WIDTH-1:0]     perf_flush_count_o,
`endif
    output logic [1:0]                ctrl_state_o
);

    ex_state_e   ex_state_q;
    ex_state_e   ex_state_d;
    ctrl_state_e state;
    pipe_ctrl_t  ctrl;
    logic        load_use;
    logic        mem_stall;
    logic        ex_wait;
    logic        do_redirect;

    load_use_detect #(
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_load_use_detect (
        .id_valid_i   (id_valid_i),
        .id_uses_rs1_i(id_uses_rs1_i),
        .id_uses_rs2_i(id_uses_rs2_i),
        .id_rs1_i     (id_rs1_i),
        .id_rs2_i     (id_rs2_i),
        .ex_valid_i   (ex_valid_i),
        .ex_is_load_i (ex_is_load_i),
        .ex_rd_i      (ex_rd_i),
        .load_use_o   (load_use)
    );

    assign mem_stall = mem_req_i && !mem_ready_i;
    // The done cycle is not a wait: EX/MEM must capture the multi-cycle result, not a bubble.
    assign ex_wait   = ((ex_state_q == ExBusy) || ex_mc_start_i) && !ex_mc_done_i;

    always_comb begin
        ex_state_d = ex_state_q;
        unique case (ex_state_q)
            ExIdle: if (ex_mc_start_i && !ex_mc_done_i && !mem_stall) ex_state_d = ExBusy;
            ExBusy: if (ex_mc_done_i && !mem_stall) ex_state_d = ExIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ex_state_q <= ExIdle;
        end else begin
            ex_state_q <= ex_state_d;
        end
    end

    // Stalls defer a redirect: EX is frozen, so ex_redirect_i is still present once they clear.
    always_comb begin
        state       = CtrlRun;
        do_redirect = 1'b0;
        if (mem_stall) begin
            state = CtrlMemWait;
        end else if (ex_wait) begin
            state = CtrlExWait;
        end else if (ex_redirect_i) begin
            do_redirect = 1'b1;
        end else if (load_use) begin
            state = CtrlLoadStall;
        end
    end

    assign ctrl           = ctrl_action(state, do_redirect);
    assign pc_en_o        = ctrl.pc_en;
    assign if_id_en_o     = ctrl.if_id_en;
    assign id_ex_en_o     = ctrl.id_ex_en;
    assign ex_mem_en_o    = ctrl.ex_mem_en;
    assign mem_wb_en_o    = ctrl.mem_wb_en;
    assign if_id_flush_o  = ctrl.if_id_flush;
    assign id_ex_flush_o  = ctrl.id_ex_flush;
    assign ex_mem_flush_o = ctrl.ex_mem_flush;
    assign ctrl_state_o   = state;

`ifdef PIPE_CTRL_PERF_EN
    localparam logic [PERF_WIDTH-1:0] PerfOne = PERF_WIDTH'(1);

    logic [PERF_WIDTH-1:0] stall_cnt_q;
    logic [PERF_WIDTH-1:0] flush_cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((state != CtrlRun) && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + PerfOne;
            end
            if (do_redirect && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + PerfOne;
            end
        end
    end

    assign perf_stall_cycles_o = stall_cnt_q;
    assign perf_flush_count_o  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed vectors push expected controls, a monitor
// compares on every falling edge.
module tb_pipeline_ctrl;

    localparam int unsigned AW = 5;

    // Expected vector layout: {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id,id_ex,ex_mem flushes, state}
    localparam logic [9:0] RUN_V  = {5'b11111, 3'b000, 2'd0};
    localparam logic [9:0] LS_V   = {5'b00111, 3'b010, 2'd1};
    localparam logic [9:0] EXW_V  = {5'b00011, 3'b001, 2'd2};
    localparam logic [9:0] MEMW_V = {5'b00000, 3'b000, 2'd3};
    localparam logic [9:0] RED_V  = {5'b11111, 3'b110, 2'd0};

    logic clk = 1'b0;
    logic reset;
    logic id_valid, id_uses_rs1, id_uses_rs2;
    logic [AW-1:0] id_rs1, id_rs2, ex_rd;
    logic ex_valid, ex_is_load, ex_mc_start, ex_mc_done, ex_redirect, mem_req, mem_ready;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, ex_mem_flush;
    logic [1:0] ctrl_state;
`ifdef PIPE_CTRL_PERF_EN
    logic [3:0] perf_stall_cycles, perf_flush_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [9:0] exp_q[$];
    string      name_q[$];

    always #5 clk = ~clk;

    pipeline_ctrl #(
        .REG_ADDR_WIDTH(AW)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .PERF_WIDTH(4)
`endif
    ) dut (
        .clk_i              (clk),
        .reset_i            (reset),
        .id_valid_i         (id_valid),
        .id_uses_rs1_i      (id_uses_rs1),
        .id_uses_rs2_i      (id_uses_rs2),
        .id_rs1_i           (id_rs1),
        .id_rs2_i           (id_rs2),
        .ex_valid_i         (ex_valid),
        .ex_is_load_i       (ex_is_load),
        .ex_rd_i            (ex_rd),
        .ex_mc_start_i      (ex_mc_start),
        .ex_mc_done_i       (ex_mc_done),
        .ex_redirect_i      (ex_redirect),
        .mem_req_i          (mem_req),
        .mem_ready_i        (mem_ready),
        .pc_en_o            (pc_en),
        .if_id_en_o         (if_id_en),
        .id_ex_en_o         (id_ex_en),
        .ex_mem_en_o        (ex_mem_en),
        .mem_wb_en_o        (mem_wb_en),
        .if_id_flush_o      (if_id_flush),
        .id_ex_flush_o      (id_ex_flush),
        .ex_mem_flush_o     (ex_mem_flush),
`ifdef PIPE_CTRL_PERF_EN
        .perf_stall_cycles_o(perf_stall_cycles),
        .perf_flush_count_o (perf_flush_count),
`endif
        .ctrl_state_o       (ctrl_state)
    );

    // Monitor: outputs are combinational, so every cycle with a queued entry is compared.
    logic [9:0] mon_act, mon_exp;
    string      mon_name;
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                mon_act  = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                            if_id_flush, id_ex_flush, ex_mem_flush, ctrl_state};
                n_checks++;
                if (mon_act !== mon_exp) begin
                    n_fail++;
                    $display("FAIL %s: got en=%b fl=%b st=%0d, expected en=%b fl=%b st=%0d",
                             mon_name, mon_act[9:5], mon_act[4:2], mon_act[1:0],
                             mon_exp[9:5], mon_exp[4:2], mon_exp[1:0]);
                end
            end
        end
    end

    task automatic clear_in();
        id_valid = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_rs1 = '0; id_rs2 = '0;
        ex_valid = 0; ex_is_load = 0; ex_rd = '0; ex_mc_start = 0; ex_mc_done = 0;
        ex_redirect = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic set_load_use(input logic [AW-1:0] r);
        id_valid = 1; id_uses_rs1 = 1; id_rs1 = r; ex_valid = 1; ex_is_load = 1; ex_rd = r;
    endtask

    // Push the expected controls for the inputs currently applied, then advance one cycle.
    task automatic step(input string name, input logic [9:0] expv);
        exp_q.push_back(expv);
        name_q.push_back(name);
        @(posedge clk);
        #1;
    endtask

`ifdef PIPE_CTRL_PERF_EN
    task automatic check_val(input string name, input logic [3:0] act, input logic [3:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        clear_in();
        reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        step("reset_idle", RUN_V);

        set_load_use(5'd5);                      step("load_use_rs1_x5", LS_V);
        ex_valid = 0; ex_is_load = 0; ex_rd = '0; step("after_bubble", RUN_V);
        id_uses_rs1 = 0; id_uses_rs2 = 1; id_rs2 = 5'd7;
        ex_valid = 1; ex_is_load = 1; ex_rd = 5'd7; step("load_use_rs2_x7", LS_V);
        id_uses_rs2 = 0;                          step("rs2_not_read", RUN_V);
        clear_in(); set_load_use(5'd0);           step("load_x0_no_stall", RUN_V);
        set_load_use(5'd5); ex_is_load = 0;       step("non_load_no_stall", RUN_V);
        set_load_use(5'd5); id_valid = 0;         step("id_invalid_no_stall", RUN_V);
        clear_in();

        ex_mc_start = 1;
        for (int i = 0; i < 4; i++) step($sformatf("mc_wait%0d", i), EXW_V);
        ex_mc_done = 1;                           step("mc_done_cycle", RUN_V);
        ex_mc_start = 0; ex_mc_done = 0;          step("mc_back_idle", RUN_V);
        ex_mc_start = 1; ex_mc_done = 1;          step("mc_start_and_done", RUN_V);
        ex_mc_start = 0; ex_mc_done = 0;          step("mc_stayed_idle", RUN_V);

        mem_req = 1; mem_ready = 0; ex_redirect = 1;
        for (int i = 0; i < 3; i++) step($sformatf("mem_wait_redirect%0d", i), MEMW_V);
        mem_ready = 1;                            step("redirect_after_mem", RED_V);
        clear_in();                               step("run_after_redirect", RUN_V);
        set_load_use(5'd9); ex_redirect = 1;      step("redirect_beats_load_use", RED_V);
        clear_in();

        ex_mc_start = 1;                          step("busy_start", EXW_V);
        ex_mc_start = 0; ex_redirect = 1;         step("redirect_deferred_ex", EXW_V);
        ex_redirect = 0; mem_req = 1; ex_mc_done = 1; step("done_under_mem_stall", MEMW_V);
        mem_req = 0; ex_mc_done = 0;              step("still_busy", EXW_V);
        ex_mc_done = 1;                           step("busy_done", RUN_V);
        ex_mc_done = 0;                           step("busy_cleared", RUN_V);
        mem_req = 1; mem_ready = 1;               step("mem_ready_no_stall", RUN_V);
        clear_in();

        ex_mc_start = 1;                          step("pre_reset_start", EXW_V);
        ex_mc_start = 0; reset = 1;               step("reset_while_busy", EXW_V);
        reset = 0;                                step("idle_after_reset", RUN_V);

`ifdef PIPE_CTRL_PERF_EN
        reset = 1; @(posedge clk); #1 reset = 0;
        check_val("perf_stall_reset", perf_stall_cycles, 4'd0);
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 20; i++) step("perf_stall", MEMW_V);
        check_val("perf_stall_saturate", perf_stall_cycles, 4'd15);
        clear_in(); ex_redirect = 1;
        step("perf_redirect0", RED_V);
        step("perf_redirect1", RED_V);
        clear_in();
        check_val("perf_flush_count", perf_flush_count, 4'd2);
`endif

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the five-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC. Each cycle it decides which registers load, which hold, and which are overwritten with a bubble. It detects load-use hazards, sequences multi-cycle EX operations (mul/div), freezes the pipe on data-memory wait, and squashes wrong-path instructions on an EX redirect. It sits beside the datapath; its outputs drive the enable and flush inputs of every pipeline register.

## Interface
- REG_ADDR_WIDTH, 5, architectural register index width
- PERF_WIDTH, 32, perf counter width (used only with PIPE_CTRL_PERF_EN)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- id_valid, id_uses_rs1, id_uses_rs2  in  1  ID holds a valid instruction; rs1/rs2 are actually read
- id_rs1, id_rs2  in  REG_ADDR_WIDTH  ID source registers
- ex_valid, ex_is_load  in  1  EX holds a valid instruction; it is a load
- ex_rd  in  REG_ADDR_WIDTH  EX destination register
- ex_mc_start  in  1  multi-cycle op present in EX (level, first cycle in EX)
- ex_mc_done  in  1  multi-cycle result valid; held high by the unit until EX/MEM loads
- ex_redirect  in  1  branch/jump resolved in EX with PC change
- mem_req, mem_ready  in  1  MEM-stage data request; memory accepted/completed
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  register load enables
- if_id_flush, id_ex_flush, ex_mem_flush  out  1  load bubble (control field zeroed) instead of data
- ctrl_state  out  2  current action, ctrl_state_e: RUN=0, LOAD_STALL=1, EX_WAIT=2, MEM_WAIT=3

## Operation
- Single registered FSM bit, ex_busy (IDLE/BUSY). All other decisions are combinational from ex_busy and the inputs.
- IDLE->BUSY when ex_mc_start & !ex_mc_done & !mem_stall. BUSY->IDLE when ex_mc_done & !mem_stall. Start and done in the same cycle: stays IDLE.
- mem_stall = mem_req & !mem_ready.
- load_use = id_valid & ex_valid & ex_is_load & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)). Register x0 never creates a hazard.
- Actions are evaluated in fixed priority, highest first:
  - MEM_WAIT (mem_stall): all enables 0, all flushes 0; the whole pipe holds.
  - EX_WAIT (ex_busy, or ex_mc_start & !ex_mc_done):
    - pc_en, if_id_en and id_ex_en are 0.
    - ex_mem_en=1 with ex_mem_flush=1, so a bubble enters MEM.
    - mem_wb_en=1.
  - Redirect (ex_redirect): all enables 1, if_id_flush=1, id_ex_flush=1. ctrl_state reports RUN.
  - LOAD_STALL (load_use):
    - pc_en and if_id_en are 0.
    - id_ex_en=1 with id_ex_flush=1, inserting one bubble.
    - EX/MEM and MEM/WB advance.
  - RUN: all enables 1, all flushes 0.
- A flush is asserted only together with the matching enable.
- Redirect during MEM_WAIT or EX_WAIT is deferred. EX is frozen, so ex_redirect persists and is honoured in the first non-stalled cycle.
- Load-use and redirect in the same cycle: the redirect wins, because the ID instruction is wrong-path.

## Timing
- Reset values: ex_busy=IDLE, ctrl_state=RUN, all enables 1, all flushes 0, perf counters 0.
- The outputs are combinational from the inputs in the same cycle; no output register.
- The load-use penalty is exactly one bubble. In the next cycle the load is in MEM and load_use is 0.
- An N-cycle multi-cycle op (done seen N-1 cycles after start) holds the front end for N-1 cycles.
- Reset during BUSY returns the FSM to IDLE in the next cycle; the multi-cycle unit is reset separately.

## Configuration
- PIPE_CTRL_PERF_EN defined adds output ports:
  - perf_stall_cycles: counts cycles with ctrl_state != RUN.
  - perf_flush_count: counts redirect flush events.
  - Both are PERF_WIDTH wide, saturate at all-ones and clear on reset.
- Without PIPE_CTRL_PERF_EN: no ports, no counters, and otherwise identical behaviour.

## Structure
- pipe_ctrl_pkg holds ctrl_state_e and the REG_ADDR_WIDTH default, shared with the decode and forwarding logic.
- One sub-module, load_use_detect, contains the comparator logic that produces load_use. It is combinational and reused by the forwarding-unit bench.

## Test plan
- Load to x5 in EX, ID reads rs1=x5 -> one cycle with pc_en=0, if_id_en=0, id_ex_flush=1, ctrl_state=1; RUN the next cycle.
- Load to x0 in EX, ID reads rs1=x0 -> no stall, all enables 1.
- ex_mc_start with ex_mc_done 4 cycles later -> 4 cycles of EX_WAIT with ex_mem_flush=1; ex_busy returns to IDLE after done.
- mem_req=1, mem_ready=0 for 3 cycles while ex_redirect=1 -> 3 cycles of all enables 0; then 1 cycle with if_id_flush=id_ex_flush=1.
- ex_redirect and load_use together -> flushes only, pc_en=1; reset asserted mid-BUSY -> IDLE and all enables 1 the next cycle.
- With PIPE_CTRL_PERF_EN and PERF_WIDTH=4 -> 20 stall cycles leave perf_stall_cycles=15.
